// File: rtl/control_alu_md.sv
// control_alu_md -- EX-stage ALU control with an optional iterative
// multiply/divide engine and HI/LO registers.
//
// Optional feature macro: CONTROL_ALU_MULDIV_EN
//   defined   : FSM, HI/LO registers and mult/div/move decode are built.
//   undefined : mult/div/move functs decode as illegal; o_Stall, o_HiLo,
//               o_HiLoSel and o_DbgState are tied to 0; purely combinational.
//
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_Valid          EX-stage instruction is valid
//   i_Funct/i_Opcode instruction funct / opcode fields
//   i_ALUOp          ALUOp from main control
//   i_RS, i_RT       operands (rs: dividend/multiplicand/MTxx source)
//   o_ALUOp          ALU operation code (1111 when illegal)
//   o_Illegal        decode matched no entry
//   o_Stall          freeze IF/ID/EX
//   o_HiLo           HI for MFHI, LO for MFLO, else 0
//   o_HiLoSel        EX result comes from o_HiLo
//   o_DbgState       FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Pipeline contract: an instruction is offered while i_Valid is high and is
// consumed on any rising edge where o_Stall is low. A MULT/DIV raises
// o_Stall in its accept cycle and every RUN cycle, so the pipeline holds the
// same instruction until DONE, where it retires without being re-accepted.
module control_alu_md #(
  parameter int NBITS        = 32,
  parameter int ANBITS       = 6,
  parameter int NBITSCONTROL = 2,
  parameter int ALUOP        = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_Valid,
  input  logic [ANBITS-1:0]       i_Funct,
  input  logic [ANBITS-1:0]       i_Opcode,
  input  logic [NBITSCONTROL-1:0] i_ALUOp,
  input  logic [NBITS-1:0]        i_RS,
  input  logic [NBITS-1:0]        i_RT,
  output logic [ALUOP-1:0]        o_ALUOp,
  output logic                    o_Illegal,
  output logic                    o_Stall,
  output logic [NBITS-1:0]        o_HiLo,
  output logic                    o_HiLoSel,
  output logic [1:0]              o_DbgState
);

  localparam logic [NBITSCONTROL-1:0] CTL_ADD   = NBITSCONTROL'(2'b00);
  localparam logic [NBITSCONTROL-1:0] CTL_SUB   = NBITSCONTROL'(2'b01);
  localparam logic [NBITSCONTROL-1:0] CTL_RTYPE = NBITSCONTROL'(2'b10);
  localparam logic [NBITSCONTROL-1:0] CTL_IMM   = NBITSCONTROL'(2'b11);

  localparam logic [ALUOP-1:0] OP_AND = ALUOP'(4'b0000);
  localparam logic [ALUOP-1:0] OP_OR  = ALUOP'(4'b0001);
  localparam logic [ALUOP-1:0] OP_ADD = ALUOP'(4'b0010);
  localparam logic [ALUOP-1:0] OP_SLL = ALUOP'(4'b0011);
  localparam logic [ALUOP-1:0] OP_SRL = ALUOP'(4'b0100);
  localparam logic [ALUOP-1:0] OP_SRA = ALUOP'(4'b0101);
  localparam logic [ALUOP-1:0] OP_SUB = ALUOP'(4'b0110);
  localparam logic [ALUOP-1:0] OP_SLT = ALUOP'(4'b0111);
  localparam logic [ALUOP-1:0] OP_NOR = ALUOP'(4'b1100);
  localparam logic [ALUOP-1:0] OP_XOR = ALUOP'(4'b1101);
  localparam logic [ALUOP-1:0] OP_BAD = ALUOP'(4'b1111);

  localparam logic [ANBITS-1:0] F_ADD  = ANBITS'(6'b100000);
  localparam logic [ANBITS-1:0] F_ADDU = ANBITS'(6'b100001);
  localparam logic [ANBITS-1:0] F_SUB  = ANBITS'(6'b100010);
  localparam logic [ANBITS-1:0] F_SUBU = ANBITS'(6'b100011);
  localparam logic [ANBITS-1:0] F_AND  = ANBITS'(6'b100100);
  localparam logic [ANBITS-1:0] F_OR   = ANBITS'(6'b100101);
  localparam logic [ANBITS-1:0] F_XOR  = ANBITS'(6'b100110);
  localparam logic [ANBITS-1:0] F_NOR  = ANBITS'(6'b100111);
  localparam logic [ANBITS-1:0] F_SLT  = ANBITS'(6'b101010);
  localparam logic [ANBITS-1:0] F_SLL  = ANBITS'(6'b000000);
  localparam logic [ANBITS-1:0] F_SRL  = ANBITS'(6'b000010);
  localparam logic [ANBITS-1:0] F_SRA  = ANBITS'(6'b000011);
  localparam logic [ANBITS-1:0] F_SLLV = ANBITS'(6'b000100);
  localparam logic [ANBITS-1:0] F_SRLV = ANBITS'(6'b000110);
  localparam logic [ANBITS-1:0] F_SRAV = ANBITS'(6'b000111);

  localparam logic [ANBITS-1:0] O_SLTI = ANBITS'(6'b001010);
  localparam logic [ANBITS-1:0] O_ANDI = ANBITS'(6'b001100);
  localparam logic [ANBITS-1:0] O_ORI  = ANBITS'(6'b001101);
  localparam logic [ANBITS-1:0] O_XORI = ANBITS'(6'b001110);

  logic rtype;
  logic md_funct;   // funct is one of the eight mult/div/move codes

  assign rtype = (i_ALUOp == CTL_RTYPE);

  // ---------------------------------------------------------------------
  // Zero-latency decode, independent of i_Valid.
  // ---------------------------------------------------------------------
  always_comb begin
    o_ALUOp   = OP_BAD;
    o_Illegal = 1'b1;
    case (i_ALUOp)
      CTL_ADD: begin o_ALUOp = OP_ADD; o_Illegal = 1'b0; end
      CTL_SUB: begin o_ALUOp = OP_SUB; o_Illegal = 1'b0; end
      CTL_RTYPE: begin
        o_Illegal = 1'b0;
        case (i_Funct)
          F_ADD, F_ADDU:  o_ALUOp = OP_ADD;
          F_SUB, F_SUBU:  o_ALUOp = OP_SUB;
          F_AND:          o_ALUOp = OP_AND;
          F_OR:           o_ALUOp = OP_OR;
          F_NOR:          o_ALUOp = OP_NOR;
          F_XOR:          o_ALUOp = OP_XOR;
          F_SLT:          o_ALUOp = OP_SLT;
          F_SLL, F_SLLV:  o_ALUOp = OP_SLL;
          F_SRL, F_SRLV:  o_ALUOp = OP_SRL;
          F_SRA, F_SRAV:  o_ALUOp = OP_SRA;
          default: begin
            // Mult/div/move ops pass a harmless ADD code down the ALU path.
            o_ALUOp   = md_funct ? OP_ADD : OP_BAD;
            o_Illegal = !md_funct;
          end
        endcase
      end
      CTL_IMM: begin
        o_Illegal = 1'b0;
        case (i_Opcode)
          O_SLTI:  o_ALUOp = OP_SLT;
          O_ANDI:  o_ALUOp = OP_AND;
          O_ORI:   o_ALUOp = OP_OR;
          O_XORI:  o_ALUOp = OP_XOR;
          default: o_Illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

`ifdef CONTROL_ALU_MULDIV_EN

  localparam logic [ANBITS-1:0] F_MFHI  = ANBITS'(6'b010000);
  localparam logic [ANBITS-1:0] F_MTHI  = ANBITS'(6'b010001);
  localparam logic [ANBITS-1:0] F_MFLO  = ANBITS'(6'b010010);
  localparam logic [ANBITS-1:0] F_MTLO  = ANBITS'(6'b010011);
  localparam logic [ANBITS-1:0] F_MULT  = ANBITS'(6'b011000);
  localparam logic [ANBITS-1:0] F_MULTU = ANBITS'(6'b011001);
  localparam logic [ANBITS-1:0] F_DIV   = ANBITS'(6'b011010);
  localparam logic [ANBITS-1:0] F_DIVU  = ANBITS'(6'b011011);
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] hi_q, hi_d, lo_q, lo_d;
  // acc: upper product half / partial remainder; mq: multiplier / quotient;
  // opnd: multiplicand / divisor magnitude.
  logic [NBITS-1:0] acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d;
  logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic             is_mul, is_div, start, is_signed, rs_neg, rt_neg;
  logic [NBITS-1:0] rs_mag, rt_mag;
  logic [NBITS:0]   mul_sum, div_shift;
  logic [NBITS+1:0] div_diff;
  logic             div_borrow, unused_diff;
  logic [NBITS-1:0] step_acc, step_mq, quo_fix, rem_fix, res_hi, res_lo;
  logic [2*NBITS-1:0] prod, prod_fix;
  logic             hilo_sel;

  assign md_funct = (i_Funct == F_MFHI) || (i_Funct == F_MTHI) ||
                    (i_Funct == F_MFLO) || (i_Funct == F_MTLO) ||
                    (i_Funct == F_MULT) || (i_Funct == F_MULTU) ||
                    (i_Funct == F_DIV)  || (i_Funct == F_DIVU);

  assign is_mul    = (i_Funct == F_MULT) || (i_Funct == F_MULTU);
  assign is_div    = (i_Funct == F_DIV)  || (i_Funct == F_DIVU);
  assign start     = i_Valid && rtype && (is_mul || is_div);
  assign is_signed = (i_Funct == F_MULT) || (i_Funct == F_DIV);
  assign rs_neg    = is_signed && i_RS[NBITS-1];
  assign rt_neg    = is_signed && i_RT[NBITS-1];
  assign rs_mag    = rs_neg ? -i_RS : i_RS;
  assign rt_mag    = rt_neg ? -i_RT : i_RT;

  // One shift-add multiply step: {carry,acc,mq} shifted right by one.
  assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring divide step: shift in the next dividend bit, keep the
  // difference only when it does not borrow. The remainder never exceeds
  // NBITS bits, so bit NBITS of the difference is always 0.
  assign div_shift   = {acc_q, mq_q[NBITS-1]};
  assign div_diff    = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_borrow  = div_diff[NBITS+1];
  assign unused_diff = div_diff[NBITS];

  assign step_acc = div_q ? (div_borrow ? div_shift[NBITS-1:0] : div_diff[NBITS-1:0])
                          : mul_sum[NBITS:1];
  assign step_mq  = div_q ? {mq_q[NBITS-2:0], ~div_borrow}
                          : {mul_sum[0], mq_q[NBITS-1:1]};

  // Sign fix-up on the final step. Divide-by-zero naturally leaves the
  // dividend in the remainder (sign restored), only the quotient is forced.
  assign prod     = {step_acc, step_mq};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = dz_q ? '1 : (neg_q ? -step_mq : step_mq);
  assign rem_fix  = rneg_q ? -step_acc : step_acc;
  assign res_hi   = div_q ? rem_fix : prod_fix[2*NBITS-1:NBITS];
  assign res_lo   = div_q ? quo_fix : prod_fix[NBITS-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    o_Stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          o_Stall = 1'b1;
          state_d = S_RUN;
          cnt_d   = CW'(NBITS);
          acc_d   = '0;
          mq_d    = is_div ? rs_mag : rt_mag;
          opnd_d  = is_div ? rt_mag : rs_mag;
          div_d   = is_div;
          neg_d   = rs_neg ^ rt_neg;
          rneg_d  = rs_neg;
          dz_d    = is_div && (i_RT == '0);
        end else if (i_Valid && rtype && (i_Funct == F_MTHI)) begin
          hi_d = i_RS;
        end else if (i_Valid && rtype && (i_Funct == F_MTLO)) begin
          lo_d = i_RS;
        end
      end
      S_RUN: begin
        o_Stall = 1'b1;
        acc_d   = step_acc;
        mq_d    = step_mq;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_reset) o_Stall = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign hilo_sel   = (state_q == S_IDLE) && rtype &&
                      ((i_Funct == F_MFHI) || (i_Funct == F_MFLO));
  assign o_HiLoSel  = hilo_sel;
  assign o_HiLo     = (i_reset || !hilo_sel) ? '0 :
                      ((i_Funct == F_MFHI) ? hi_q : lo_q);
  assign o_DbgState = state_q;

`else

  logic unused_inputs;

  assign md_funct      = 1'b0;
  assign o_Stall       = 1'b0;
  assign o_HiLo        = '0;
  assign o_HiLoSel     = 1'b0;
  assign o_DbgState    = 2'b00;
  assign unused_inputs = ^{i_clk, i_reset, i_Valid, i_RS, i_RT};

`endif

endmodule

// File: doc/control_alu_md.md
# control_alu_md

Next-generation ALU control unit for the EX stage. It decodes `i_ALUOp`, `i_Funct` and `i_Opcode` into the 4-bit ALU operation code, as the current decoder does, and adds a dedicated illegal-operation flag. It also contains an iterative multiply/divide engine with HI/LO registers, which stalls the pipeline while an operation is in flight.

## Interface
- `NBITS`, 32, operand, HI and LO width (≥ 4).
- `ANBITS`, 6, funct/opcode width.
- `NBITSCONTROL`, 2, main-control ALUOp width.
- `ALUOP`, 4, ALU operation code width.
- `i_clk` input 1: single clock, all state on rising edge.
- `i_reset` input 1: synchronous, active-high.
- `i_Valid` input 1: the EX-stage instruction is valid.
- `i_Funct` input ANBITS: instruction funct field.
- `i_Opcode` input ANBITS: instruction opcode.
- `i_ALUOp` input NBITSCONTROL: from main control.
- `i_RS` input NBITS: rs operand (dividend / multiplicand / MTHI/MTLO source).
- `i_RT` input NBITS: rt operand (divisor / multiplier).
- `o_ALUOp` output ALUOP: ALU operation code.
- `o_Illegal` output 1: the decode matched no entry.
- `o_Stall` output 1: freeze IF/ID/EX.
- `o_HiLo` output NBITS: HI for MFHI, LO for MFLO, else 0.
- `o_HiLoSel` output 1: EX result is taken from `o_HiLo`.

## Operation
- **Combinational decode**, regardless of `i_Valid`:
  - `i_ALUOp`=00 gives 0010. `i_ALUOp`=01 gives 0110.
  - `i_ALUOp`=10 decodes funct:
    - ADD 100000 / ADDU 100001 → 0010
    - SUB 100010 / SUBU 100011 → 0110
    - AND 100100 → 0000
    - OR 100101 → 0001
    - NOR 100111 → 1100
    - XOR 100110 → 1101
    - SLT 101010 → 0111
    - SLL 000000 / SLLV 000100 → 0011
    - SRL 000010 / SRLV 000110 → 0100
    - SRA 000011 / SRAV 000111 → 0101
  - `i_ALUOp`=11 decodes opcode: SLTI 001010 → 0111, ANDI 001100 → 0000, ORI 001101 → 0001, XORI 001110 → 1101.
  - Any other combination: `o_ALUOp`=1111 and `o_Illegal`=1. There are no negative sentinel codes.
- **Mult/div funct codes** (valid only with `i_ALUOp`=10): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - For these codes `o_ALUOp`=0010 and `o_Illegal`=0.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN when `i_Valid` and the funct is MULT/MULTU/DIV/DIVU. Operands are latched and the iteration counter is loaded with NBITS.
  - RUN stays in RUN while the counter is nonzero, with one shift-add (multiply) or restoring-subtract (divide) step per cycle. RUN → DONE on the step where the counter reaches 0. HI/LO are written on that edge.
  - DONE → IDLE unconditionally. In DONE the stalled instruction retires and is never re-accepted.
- **Arithmetic:**
  - Signed operations work on magnitudes and fix signs at the end.
  - MULT: {HI,LO} is the signed 2·NBITS product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Unsigned variants take the operands raw.
  - Most-negative ÷ −1: LO = 100…0, HI = 0.
  - Divide by zero (DIV or DIVU): HI = dividend, LO = all ones.
- **HI/LO moves:**
  - MFHI/MFLO: `o_HiLoSel`=1, `o_HiLo`=HI/LO combinationally. This applies in IDLE only; during RUN the stall covers it.
  - MTHI/MTLO with `i_Valid` in IDLE write `i_RS` to HI/LO at the edge.
- **Reset:** HI=LO=0, state IDLE, counter 0. Reset aborts any operation; no partial result is written.

## Timing
- `o_Stall` is combinational. It is 1 in the IDLE accept cycle and in every RUN cycle, and 0 in DONE and in IDLE otherwise.
- Stall length for a MULT/DIV is exactly NBITS+1 cycles. HI/LO become valid in DONE, one cycle after the last stall cycle.
- Back-to-back case: a MFLO presented right after DONE (in IDLE) reads the new LO. A new MULT directly after DONE is accepted in the following IDLE cycle.
- Reset-time output values: `o_Stall`=0 and `o_HiLo`=0. `o_ALUOp`, `o_Illegal` and `o_HiLoSel` follow the decode of the inputs.
- The decode outputs have zero latency; there are no registers on the ALU-op path.

## Configuration
- `CONTROL_ALU_MULDIV_EN` defined: the FSM, HI/LO registers and the mult/div/move decode are present.
- Macro undefined:
  - The eight mult/div/move functs decode as illegal (1111, `o_Illegal`=1).
  - `o_Stall`, `o_HiLo` and `o_HiLoSel` are tied to 0, and no sequential logic remains.

## Test plan
- Sweep of every listed funct and opcode, plus `i_ALUOp`=10 with funct 111111 → table codes; the sweep gives 1111 with `o_Illegal`=1 and XOR stays 1101.
- MULT with RS=0xFFFFFFFE (−2), RT=3 (NBITS=32) → stall high for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO next returns 0xFFFFFFFA.
- DIVU with RS=7, RT=0 → HI=7, LO=0xFFFFFFFF. DIV with RS=−7, RT=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV with RS=0x80000000, RT=0xFFFFFFFF → LO=0x80000000, HI=0.
- `i_reset` pulsed in RUN cycle 10 of a MULT → next cycle `o_Stall`=0, HI=LO=0, and MFHI returns 0.
- MTHI of 0x12345678 followed by MULTU with RS=RT=0x10000 → stall, then HI=1, LO=0; the DONE cycle shows no re-accept (stall stays 0).
